mem_port_arbiter: RTL and testbench

Sequencing controller that shares the single data-memory RAM port between two requesters: the instruction-side refill path (I) and the data-cache path (D). Accepts one request at a time, drives the RAM command for exactly one cycle, counts out the fixed RAM read latency and returns read data or a write acknowledge to the granted requester. It sits between the cache controllers and `ram2port`, replacing direct cache-to-RAM wiring.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the I-side refill path and the D-cache path.
// Grant in G, RAM command in G+1, response in G+1+RAM_LATENCY, next grant in G+2+RAM_LATENCY.
// Backpressure: requesters hold req until their combinational gnt; none granted while busy.
//
// Ports: i_* (I read requests), d_* (D read/write requests), ram_* (RAM command and
// read data), busy (state not IDLE). Optional build macro MEM_ARB_RR_EN selects
// round-robin arbitration on contention instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(RAM_LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  cap_we;
    logic                  cap_d;      // owner of the transaction in flight: 1 = D, 0 = I
    logic                  grant_i;
    logic                  grant_d;
    logic                  resp;

    // Grants are gated by rst_n so that nothing is granted while reset is held,
    // even though the request inputs may already be high.
`ifdef MEM_ARB_RR_EN
    logic last_d;              // 1 = D won the most recent grant

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n && state == IDLE) begin
            if (i_req && d_req) begin
                // Contention: the side that did not win last time goes now.
                grant_d = !last_d;
                grant_i = last_d;
            end else begin
                grant_d = d_req;
                grant_i = i_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (grant_i || grant_d) begin
            last_d <= grant_d;
        end
    end
`else
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n && state == IDLE) begin
            grant_d = d_req;
            grant_i = i_req && !d_req;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
            cap_d     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_i || grant_d) begin
                cap_addr  <= grant_d ? d_addr : i_addr;
                cap_wdata <= grant_d ? d_wdata : '0;
                cap_we    <= grant_d && d_we;
                cap_d     <= grant_d;
            end
            if (state == ISSUE) begin
                cnt <= LAT_M1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        resp      = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                if (grant_i || grant_d) state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_en    = 1'b1;
                ram_we    = cap_we;
                ram_addr  = cap_addr;
                ram_wdata = cap_wdata;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Counter at zero marks the cycle in which ram_rdata is valid.
                if (cnt == 4'd0) begin
                    resp      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = resp && !cap_d;
    assign d_rvalid = resp && cap_d;
    assign i_rdata  = i_rvalid ? ram_rdata : '0;
    assign d_rdata  = d_rvalid ? ram_rdata : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at RAM latency 2, one at latency 1,
// each attached to a simple behavioural RAM; transactions are checked against
// a transaction-level model of arbitration, timing and memory contents.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: RAM_LATENCY = 2
    logic        a_i_req, a_i_gnt, a_i_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_ram_en, a_ram_we, a_busy;
    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
    // Instance B: RAM_LATENCY = 1
    logic        b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_ram_en, b_ram_we, b_busy;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // Power-up RAM contents; 0x100 holds the pattern used by the directed read.
    function automatic logic [31:0] init_val(input int a);
        if (a == 'h100) return 32'hDEADBEEF;
        return 32'hC0DE_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    // Behavioural RAMs: read data valid RAM_LATENCY cycles after the command cycle.
    bit          wv_a [0:1023];
    logic [31:0] wd_a [0:1023];
    logic [31:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        if (a_ram_en && a_ram_we) begin
            wv_a[a_ram_addr[9:0]] <= 1'b1;
            wd_a[a_ram_addr[9:0]] <= a_ram_wdata;
        end
        pa0 <= wv_a[a_ram_addr[9:0]] ? wd_a[a_ram_addr[9:0]] : init_val(int'(a_ram_addr[9:0]));
        pa1 <= pa0;
        pb0 <= init_val(int'(b_ram_addr[9:0]));
    end
    assign a_ram_rdata = pa1;
    assign b_ram_rdata = pb0;

    // Reference model state
    logic [31:0] shadow [int];
    bit          model_last_d;

    function automatic logic [31:0] exp_mem(input int a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    function automatic bit exp_winner_d(input bit ir, input bit dr);
        if (RR && ir && dr) return !model_last_d;
        return dr;
    endfunction

    // Event logs for instance A
    typedef struct { int c; bit d; } gnt_t;
    typedef struct { int c; bit we; logic [31:0] addr; logic [31:0] wdata; } iss_t;
    typedef struct { int c; bit d; logic [31:0] data; } rsp_t;
    gnt_t gq[$];
    iss_t iq[$];
    rsp_t rq[$];
    int   viol = 0;
    int   last_busy = -1;

    always @(negedge clk) begin
        if (a_i_gnt) gq.push_back('{c: cyc, d: 1'b0});
        if (a_d_gnt) gq.push_back('{c: cyc, d: 1'b1});
        if (a_ram_en) iq.push_back('{c: cyc, we: a_ram_we, addr: a_ram_addr, wdata: a_ram_wdata});
        if (a_i_rvalid) rq.push_back('{c: cyc, d: 1'b0, data: a_i_rdata});
        if (a_d_rvalid) rq.push_back('{c: cyc, d: 1'b1, data: a_d_rdata});
        if (a_busy) last_busy = cyc;
        if ((!a_i_rvalid && a_i_rdata != 0) || (!a_d_rvalid && a_d_rdata != 0) ||
            (a_ram_we && !a_ram_en) || (a_i_gnt && a_d_gnt) || (a_i_rvalid && a_d_rvalid) ||
            (!b_i_rvalid && b_i_rdata != 0) || (b_ram_we && !b_ram_en))
            viol++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400us");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && a_busy; k++) tick();
        checks++;
        if (a_busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b after 20 cycles, required 0", a_busy);
        end
    endtask

    // Returns at the start of the cycle after the grant.
    task automatic await_grant();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (a_i_gnt || a_d_gnt) got = 1'b1;
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: no grant in 20 cycles, required one");
        end
    endtask

    task automatic finish_txn(input int r0);
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        for (int k = 0; k < 20 && rq.size() == r0; k++) tick();
        checks++;
        if (rq.size() == r0) begin
            errors++;
            $display("FAIL resp_timeout: no rvalid in 20 cycles, required one");
        end
        wait_idle();
    endtask

    task automatic do_txn(input bit ir, input bit dr, input bit we,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        int r0;
        r0 = rq.size();
        a_i_addr  = ia;
        a_d_addr  = da;
        a_d_we    = we;
        a_d_wdata = wd;
        a_i_req   = ir;
        a_d_req   = dr;
        await_grant();
        finish_txn(r0);
    endtask

    task automatic test_reset();
        int r0;
        rst_n = 1'b0;
        a_i_req = 1'b1; a_d_req = 1'b1; a_d_we = 1'b0;
        a_i_addr = 32'h0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
        b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_i_addr = 32'h0; b_d_addr = 32'h0; b_d_wdata = 32'h0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({a_i_gnt, a_i_rvalid, a_i_rdata, a_d_gnt, a_d_rvalid, a_d_rdata, a_ram_en, a_ram_we,
             a_ram_addr, a_ram_wdata, a_busy, b_i_gnt, b_d_gnt, b_ram_en, b_ram_addr, b_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt i/d=%0b/%0b ram_en=%0b addr=%h busy=%0b, required all 0",
                     a_i_gnt, a_d_gnt, a_ram_en, a_ram_addr, a_busy);
        end
        tick();
        r0 = rq.size();
        rst_n = 1'b1;
        model_last_d = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_d_gnt, a_i_gnt} !== {exp_winner_d(1'b1, 1'b1), !exp_winner_d(1'b1, 1'b1)}) begin
            errors++;
            $display("FAIL reset_release_grant: d_gnt=%0b i_gnt=%0b, required d_gnt=1 i_gnt=0", a_d_gnt, a_i_gnt);
        end
        model_last_d = exp_winner_d(1'b1, 1'b1);
        tick();
        finish_txn(r0);
    endtask

    task automatic test_d_read();
        int g0, i0, r0, g;
        g0 = gq.size(); i0 = iq.size(); r0 = rq.size();
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0);
        model_last_d = 1'b1;
        checks++;
        if (gq.size() != g0 + 1 || iq.size() != i0 + 1 || rq.size() != r0 + 1) begin
            errors++;
            $display("FAIL d_read_counts: grants=%0d issues=%0d resps=%0d, required 1 each",
                     gq.size() - g0, iq.size() - i0, rq.size() - r0);
            return;
        end
        g = gq[g0].c;
        checks++;
        if (gq[g0].d !== 1'b1) begin errors++; $display("FAIL d_read_owner: d=%0b, required 1", gq[g0].d); end
        checks++;
        if (iq[i0].c != g + 1 || iq[i0].addr !== 32'h100 || iq[i0].we !== 1'b0) begin
            errors++;
            $display("FAIL d_read_issue: cyc=+%0d addr=%h we=%0b, required +1 100 0", iq[i0].c - g, iq[i0].addr, iq[i0].we);
        end
        checks++;
        if (rq[r0].c != g + 3 || rq[r0].d !== 1'b1) begin
            errors++;
            $display("FAIL d_read_resp_time: cyc=+%0d d=%0b, required +3 1", rq[r0].c - g, rq[r0].d);
        end
        checks++;
        if (rq[r0].data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL d_read_data: got %h, required deadbeef", rq[r0].data);
        end
        checks++;
        if (last_busy != g + 3) begin
            errors++;
            $display("FAIL d_read_busy: last busy cycle +%0d, required +3", last_busy - g);
        end
    endtask

    task automatic test_d_write();
        int i0, r0, g;
        i0 = iq.size(); r0 = rq.size();
        do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h12345678);
        shadow['h40] = 32'h12345678;
        model_last_d = 1'b1;
        g = gq[gq.size() - 1].c;
        checks++;
        if (iq.size() != i0 + 1) begin
            errors++;
            $display("FAIL d_write_issue_count: %0d ram_en cycles, required 1", iq.size() - i0);
        end else begin
            checks++;
            if (iq[i0].we !== 1'b1 || iq[i0].addr !== 32'h40 || iq[i0].wdata !== 32'h12345678 || iq[i0].c != g + 1) begin
                errors++;
                $display("FAIL d_write_issue: we=%0b addr=%h wdata=%h cyc=+%0d, required 1 40 12345678 +1",
                         iq[i0].we, iq[i0].addr, iq[i0].wdata, iq[i0].c - g);
            end
        end
        checks++;
        if (rq.size() != r0 + 1 || rq[r0].c != g + 3 || rq[r0].d !== 1'b1) begin
            errors++;
            $display("FAIL d_write_ack: resps=%0d, required one D ack at +3", rq.size() - r0);
        end
        r0 = rq.size();
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
        checks++;
        if (rq.size() != r0 + 1 || rq[r0].data !== exp_mem('h40)) begin
            errors++;
            $display("FAIL d_write_readback: got %h, required %h", rq[rq.size() - 1].data, exp_mem('h40));
        end
    endtask

    task automatic test_contention();
        int g0, r0;
        bit w;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_last_d = 1'b0;
        tick();
        g0 = gq.size(); r0 = rq.size();
        a_i_addr = 32'h20; a_d_addr = 32'h30; a_d_we = 1'b0;
        a_i_req = 1'b1; a_d_req = 1'b1;
        for (int k = 0; k < 40 && gq.size() < g0 + 4; k++) tick();
        a_i_req = 1'b0; a_d_req = 1'b0;
        for (int k = 0; k < 20 && rq.size() < r0 + 4; k++) tick();
        wait_idle();
        checks++;
        if (gq.size() != g0 + 4 || rq.size() != r0 + 4) begin
            errors++;
            $display("FAIL contention_counts: grants=%0d resps=%0d, required 4 4", gq.size() - g0, rq.size() - r0);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            w = exp_winner_d(1'b1, 1'b1);
            model_last_d = w;
            checks++;
            if (gq[g0 + k].d !== w) begin
                errors++;
                $display("FAIL contention_winner%0d: d=%0b, required %0b", k, gq[g0 + k].d, w);
            end
            checks++;
            if (rq[r0 + k].d !== w || rq[r0 + k].data !== exp_mem(w ? 'h30 : 'h20)) begin
                errors++;
                $display("FAIL contention_resp%0d: d=%0b data=%h, required %0b %h",
                         k, rq[r0 + k].d, rq[r0 + k].data, w, exp_mem(w ? 'h30 : 'h20));
            end
            if (k > 0) begin
                checks++;
                if (gq[g0 + k].c - gq[g0 + k - 1].c != 4) begin
                    errors++;
                    $display("FAIL contention_spacing%0d: %0d cycles, required 4", k, gq[g0 + k].c - gq[g0 + k - 1].c);
                end
            end
        end
    endtask

    task automatic test_random();
        int g0, i0, r0, g, ia, da;
        bit ir, dr, we, w;
        logic [1:0]  pat;
        logic [31:0] wd, ea;
        for (int n = 0; n < 24; n++) begin
            pat = 2'($urandom_range(1, 3));
            ir = pat[0]; dr = pat[1];
            we = 1'($urandom_range(0, 1));
            ia = $urandom_range(0, 63);
            da = $urandom_range(0, 63);
            wd = $urandom;
            w  = exp_winner_d(ir, dr);
            model_last_d = w;
            ea = w ? 32'(da) : 32'(ia);
            g0 = gq.size(); i0 = iq.size(); r0 = rq.size();
            do_txn(ir, dr, we, 32'(ia), 32'(da), wd);
            checks++;
            if (gq.size() != g0 + 1 || iq.size() != i0 + 1 || rq.size() != r0 + 1) begin
                errors++;
                $display("FAIL rand%0d_counts: grants=%0d issues=%0d resps=%0d, required 1 each",
                         n, gq.size() - g0, iq.size() - i0, rq.size() - r0);
                continue;
            end
            g = gq[g0].c;
            checks++;
            if (gq[g0].d !== w || rq[r0].d !== w) begin
                errors++;
                $display("FAIL rand%0d_owner: gnt d=%0b resp d=%0b, required %0b (i_req=%0b d_req=%0b)",
                         n, gq[g0].d, rq[r0].d, w, ir, dr);
            end
            checks++;
            if (iq[i0].addr !== ea || iq[i0].we !== (w && we) || iq[i0].c != g + 1 ||
                ((w && we) && iq[i0].wdata !== wd)) begin
                errors++;
                $display("FAIL rand%0d_issue: addr=%h we=%0b wdata=%h, required %h %0b %h",
                         n, iq[i0].addr, iq[i0].we, iq[i0].wdata, ea, w && we, wd);
            end
            checks++;
            if (rq[r0].c != g + 3) begin
                errors++;
                $display("FAIL rand%0d_resp_time: +%0d, required +3", n, rq[r0].c - g);
            end
            if (w && we) begin
                shadow[da] = wd;
            end else begin
                checks++;
                if (rq[r0].data !== exp_mem(int'(ea))) begin
                    errors++;
                    $display("FAIL rand%0d_data: got %h, required %h", n, rq[r0].data, exp_mem(int'(ea)));
                end
            end
        end
    endtask

    task automatic test_latency1();
        int g, rv_c, g2;
        logic [31:0] rv_d;
        bit got;
        rv_c = -1; g2 = -1; rv_d = 32'h0;
        b_i_addr = 32'h8;
        b_i_req = 1'b1;
        @(negedge clk);
        got = b_i_gnt;
        g = cyc;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL lat1_grant: i_gnt=%0b, required 1", b_i_gnt);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            if (b_i_rvalid && rv_c < 0) begin rv_c = cyc; rv_d = b_i_rdata; end
            if (b_i_gnt && g2 < 0) g2 = cyc;
        end
        tick();
        b_i_req = 1'b0;
        for (int k = 0; k < 20 && b_busy; k++) tick();
        checks++;
        if (rv_c != g + 2 || rv_d !== init_val('h8)) begin
            errors++;
            $display("FAIL lat1_resp: rvalid at +%0d data=%h, required +2 %h", rv_c - g, rv_d, init_val('h8));
        end
        checks++;
        if (g2 != g + 3) begin
            errors++;
            $display("FAIL lat1_next_grant: +%0d, required +3", g2 - g);
        end
        checks++;
        if (b_busy) begin
            errors++;
            $display("FAIL lat1_idle: busy=%0b, required 0", b_busy);
        end
    endtask

    task automatic test_reset_mid();
        int g0, r0;
        g0 = gq.size(); r0 = rq.size();
        a_i_addr = 32'h8; a_i_req = 1'b1;
        await_grant();
        a_i_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_last_d = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (rq.size() != r0 || gq.size() != g0 + 1 || a_busy) begin
            errors++;
            $display("FAIL reset_mid_abort: resps=%0d grants=%0d busy=%0b, required 0 1 0",
                     rq.size() - r0, gq.size() - g0, a_busy);
        end
        do_txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
        model_last_d = 1'b0;
        checks++;
        if (rq.size() != r0 + 1 || rq[r0].d !== 1'b0 || rq[r0].data !== exp_mem('h8)) begin
            errors++;
            $display("FAIL reset_mid_recover: resps=%0d data=%h, required 1 I resp %h",
                     rq.size() - r0, rq[rq.size() - 1].data, exp_mem('h8));
        end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL idle_outputs: %0d cycles with stray rdata/ram_we/double grant, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_d_read();
        test_d_write();
        test_contention();
        test_random();
        test_latency1();
        test_reset_mid();
        test_idle_outputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
